// File: rtl/synch_mod_count_if.sv
// Bus bundle for synch_mod_count: control inputs and the count/flag outputs.
// Clock and reset are kept outside the bundle as plain ports.
interface synch_mod_count_if #(
    parameter int unsigned Nbits = 4
);
    logic             ena;
    logic             up;
    logic             load;
    logic [Nbits-1:0] load_val;
    logic [Nbits-1:0] counter;
    logic             tc;
    logic             ovf;

    modport master (
        output ena, up, load, load_val,
        input  counter, tc, ovf
    );

    modport slave (
        input  ena, up, load, load_val,
        output counter, tc, ovf
    );
endinterface

// File: rtl/synch_mod_count.sv
// Programmable modulo counter: up/down, parallel load, enable prescaler,
// wrap or saturate at the bounds, terminal-count and overflow flags.
module synch_mod_count #(
    parameter int unsigned     Nbits    = 4,
    parameter longint unsigned MODULUS  = 64'd1 << Nbits,
    parameter int unsigned     PRESC    = 1,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    synch_mod_count_if.slave bus
);
    localparam int unsigned     PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0]   PLAST = PW'(PRESC - 1);
    localparam logic [Nbits:0]  MAXV  = (Nbits+1)'(MODULUS - 64'd1);
    localparam logic [Nbits:0]  ONE   = (Nbits+1)'(1);

    logic [Nbits-1:0] r_counter;
    logic [PW-1:0]    r_pcnt;
    logic             r_ovf;

    logic [Nbits-1:0] w_counter_nxt;
    logic [PW-1:0]    w_pcnt_nxt;
    logic             w_ovf_nxt;
    logic [Nbits:0]   w_cnt_ext;
    logic [Nbits:0]   w_lv_ext;
    logic [Nbits:0]   w_sum;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_step;

    // One bit of headroom keeps the compare and +/-1 exact when MODULUS == 2**Nbits.
    assign w_cnt_ext = {1'b0, r_counter};
    assign w_lv_ext  = {1'b0, bus.load_val};
    assign w_at_max  = (w_cnt_ext == MAXV);
    assign w_at_zero = (r_counter == '0);
    assign w_step    = bus.ena && (r_pcnt == PLAST);

    always_comb begin
        w_sum      = w_cnt_ext;
        w_pcnt_nxt = r_pcnt;
        w_ovf_nxt  = 1'b0;
        if (bus.load) begin
            w_sum      = (w_lv_ext > MAXV) ? MAXV : w_lv_ext;
            w_pcnt_nxt = '0;
        end else if (w_step) begin
            w_pcnt_nxt = '0;
            if (bus.up) begin
                if (w_at_max) begin
                    w_ovf_nxt = 1'b1;
                    w_sum     = SATURATE ? w_cnt_ext : '0;
                end else begin
                    w_sum = w_cnt_ext + ONE;
                end
            end else begin
                if (w_at_zero) begin
                    w_ovf_nxt = 1'b1;
                    w_sum     = SATURATE ? w_cnt_ext : MAXV;
                end else begin
                    w_sum = w_cnt_ext - ONE;
                end
            end
        end else if (bus.ena) begin
            w_pcnt_nxt = r_pcnt + PW'(1);
        end
        w_counter_nxt = w_sum[Nbits-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_counter <= '0;
            r_pcnt    <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_counter <= w_counter_nxt;
            r_pcnt    <= w_pcnt_nxt;
            r_ovf     <= w_ovf_nxt;
        end
    end

    assign bus.counter = r_counter;
    assign bus.ovf     = r_ovf;
    assign bus.tc      = (bus.up && w_at_max) || (!bus.up && w_at_zero);
endmodule

// File: tb/tb_synch_mod_count.sv
// Directed-vector bench for synch_mod_count: wrap, saturate and prescaled
// instances share one stimulus set; each vector checks the selected instance.
module tb_synch_mod_count;
    logic       clk = 1'b0;
    logic       s_rst = 1'b1;
    logic       s_ena = 1'b0;
    logic       s_up = 1'b1;
    logic       s_load = 1'b0;
    logic [3:0] s_lv = '0;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    synch_mod_count_if #(.Nbits(4)) if_w ();
    synch_mod_count_if #(.Nbits(4)) if_s ();
    synch_mod_count_if #(.Nbits(4)) if_p ();

    assign if_w.ena = s_ena;  assign if_w.up = s_up;  assign if_w.load = s_load;  assign if_w.load_val = s_lv;
    assign if_s.ena = s_ena;  assign if_s.up = s_up;  assign if_s.load = s_load;  assign if_s.load_val = s_lv;
    assign if_p.ena = s_ena;  assign if_p.up = s_up;  assign if_p.load = s_load;  assign if_p.load_val = s_lv;

    synch_mod_count #(.Nbits(4), .MODULUS(10), .PRESC(1), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(s_rst), .bus(if_w.slave));
    synch_mod_count #(.Nbits(4), .MODULUS(10), .PRESC(1), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(s_rst), .bus(if_s.slave));
    synch_mod_count #(.Nbits(4), .MODULUS(10), .PRESC(3), .SATURATE(1'b0)) u_presc (
        .clk(clk), .rst(s_rst), .bus(if_p.slave));

    typedef struct {
        int         sel;   // 0 = wrap, 1 = saturate, 2 = prescale-by-3
        logic       rst;
        logic       load;
        logic       ena;
        logic       up;
        logic [3:0] lv;
        logic [3:0] cnt;
        logic       tc;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int sel, logic rst, logic load, logic ena, logic up,
                                logic [3:0] lv, logic [3:0] cnt, logic tc, logic ovf);
        vec_t v;
        v.sel = sel; v.rst = rst; v.load = load; v.ena = ena; v.up = up;
        v.lv = lv; v.cnt = cnt; v.tc = tc; v.ovf = ovf;
        return v;
    endfunction

    task automatic check_out(input int sel, input string name,
                             input logic [3:0] cnt, input logic tc, input logic ovf);
        logic [3:0] a_cnt;
        logic       a_tc;
        logic       a_ovf;
        case (sel)
            0:       begin a_cnt = if_w.counter; a_tc = if_w.tc; a_ovf = if_w.ovf; end
            1:       begin a_cnt = if_s.counter; a_tc = if_s.tc; a_ovf = if_s.ovf; end
            default: begin a_cnt = if_p.counter; a_tc = if_p.tc; a_ovf = if_p.ovf; end
        endcase
        n_cmp += 3;
        if (a_cnt !== cnt) begin
            n_fail++;
            $display("FAIL %s counter: got %0d want %0d", name, a_cnt, cnt);
        end
        if (a_tc !== tc) begin
            n_fail++;
            $display("FAIL %s tc: got %b want %b", name, a_tc, tc);
        end
        if (a_ovf !== ovf) begin
            n_fail++;
            $display("FAIL %s ovf: got %b want %b", name, a_ovf, ovf);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        s_rst = v.rst; s_load = v.load; s_ena = v.ena; s_up = v.up; s_lv = v.lv;
        @(posedge clk);
        #1;
        check_out(v.sel, name, v.cnt, v.tc, v.ovf);
    endtask

    initial begin
        // sel rst ld ena up lv | cnt tc ovf
        // Wrap, counting up 0..9,0,1 after a 2-cycle reset
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 3, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 4, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 5, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 6, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 7, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 8, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 9, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 0));
        // Wrap, counting down from a load of 2
        tbl.push_back(mk(0, 0, 1, 0, 0, 2, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 9, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 8, 0, 0));
        // Load clamp, load beats ena, rst beats load
        tbl.push_back(mk(0, 0, 1, 0, 1, 15, 9, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 4, 4, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 7, 0, 0, 0));
        // Direction reversal, no ovf
        tbl.push_back(mk(0, 0, 1, 0, 1, 4, 4, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 5, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 6, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 5, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 4, 0, 0));
        // Saturate: up from 7 holds at 9 with ovf on each blocked step
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 7, 7, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 8, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 9, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 9, 1, 1));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 9, 1, 1));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 9, 1, 1));
        // Saturate at zero going down
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Saturate: tc follows up immediately, then one step down from 9
        apply(mk(1, 0, 1, 0, 1, 9, 9, 1, 0), "sat_load9");
        s_up = 1'b0;
        #1;
        check_out(1, "sat_tc_drop", 4'd9, 1'b0, 1'b0);
        apply(mk(1, 0, 0, 1, 0, 0, 8, 0, 0), "sat_down");

        // Prescale by 3: step on every 3rd enabled cycle, stall keeps phase
        apply(mk(2, 1, 0, 0, 1, 0, 0, 0, 0), "p_rst");
        apply(mk(2, 0, 0, 1, 1, 0, 0, 0, 0), "p_e1");
        apply(mk(2, 0, 0, 1, 1, 0, 0, 0, 0), "p_e2");
        apply(mk(2, 0, 0, 1, 1, 0, 1, 0, 0), "p_e3");
        apply(mk(2, 0, 0, 1, 1, 0, 1, 0, 0), "p_e4");
        apply(mk(2, 0, 0, 1, 1, 0, 1, 0, 0), "p_e5");
        apply(mk(2, 0, 0, 1, 1, 0, 2, 0, 0), "p_e6");
        apply(mk(2, 0, 0, 1, 1, 0, 2, 0, 0), "p_e7");
        apply(mk(2, 0, 0, 0, 1, 0, 2, 0, 0), "p_stall1");
        apply(mk(2, 0, 0, 0, 1, 0, 2, 0, 0), "p_stall2");
        apply(mk(2, 0, 0, 1, 1, 0, 2, 0, 0), "p_e8");
        apply(mk(2, 0, 0, 1, 1, 0, 3, 0, 0), "p_e9");
        // Load mid-phase restarts the prescaler
        apply(mk(2, 0, 0, 1, 1, 0, 3, 0, 0), "p_e10");
        apply(mk(2, 0, 1, 1, 1, 5, 5, 0, 0), "p_load");
        apply(mk(2, 0, 0, 1, 1, 0, 5, 0, 0), "p_l1");
        apply(mk(2, 0, 0, 1, 1, 0, 5, 0, 0), "p_l2");
        apply(mk(2, 0, 0, 1, 1, 0, 6, 0, 0), "p_l3");
        // Prescaled wrap: ovf once per 3 cycles at the bound
        apply(mk(2, 0, 1, 0, 1, 9, 9, 1, 0), "p_load9");
        apply(mk(2, 0, 0, 1, 1, 0, 9, 1, 0), "p_w1");
        apply(mk(2, 0, 0, 1, 1, 0, 9, 1, 0), "p_w2");
        apply(mk(2, 0, 0, 1, 1, 0, 0, 0, 1), "p_w3");
        apply(mk(2, 0, 0, 1, 1, 0, 0, 0, 0), "p_w4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
